// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write scheduler.
//   NUM_REGS / ADDR_W / DATA_W : register-file geometry
//   state_e                    : scheduler FSM states
//   grant_e                    : identity of the most recently granted requester
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int DATA_W   = 32;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_e;

  typedef enum logic {
    GNT_ALU,
    GNT_MEM
  } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst   : clock, async active-high reset
//   req_alu    : ALU writeback request
//   req_mem    : load writeback request
//   en         : arbitration enable; no grant is issued while low
//   update     : a granted transfer completed this cycle; record the winner
//   grant[1:0] : one-hot grant, bit 0 = ALU, bit 1 = MEM
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_alu,
  input  logic       req_mem,
  input  logic       en,
  input  logic       update,
  output logic [1:0] grant
);

  grant_e last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req_alu && req_mem) begin
        // On a tie, favour whichever side did not win last time.
        grant = (last_grant == GNT_MEM) ? 2'b01 : 2'b10;
      end else begin
        grant = {req_mem, req_alu};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Starting as MEM lets the ALU win the first tie after reset.
      last_grant <= GNT_MEM;
    end else if (update && (grant != 2'b00)) begin
      last_grant <= grant[0] ? GNT_ALU : GNT_MEM;
    end
  end

endmodule

// File: rtl/regfile_write_sched.sv
// Write-port scheduler and clear sequencer for the general-purpose register file.
// Shares the single write port between ALU and load writeback with round-robin
// arbitration, drops writes to register 0, and on request sweeps every entry to
// zero at one register per cycle.
//
//   CLK, MasterReset     : clock, async active-high reset
//   clearReq             : one-cycle pulse starting a full clear sweep
//   clearBusy            : high while the sweep is in progress
//   aluValid/aluReady    : ALU writeback handshake, aluReg/aluData payload
//   memValid/memReady    : load writeback handshake, memReg/memData payload
//   RegWrite/writeReg/writeData : registered write port to the register file
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | arbitrating writeback requests; clearReq starts a sweep
// S_CLEAR | writing zero to register `counter`, both readies held low
module regfile_write_sched #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              MasterReset,
  input  logic              clearReq,
  output logic              clearBusy,
  input  logic              aluValid,
  output logic              aluReady,
  input  logic [ADDR_W-1:0] aluReg,
  input  logic [DATA_W-1:0] aluData,
  input  logic              memValid,
  output logic              memReady,
  input  logic [ADDR_W-1:0] memReg,
  input  logic [DATA_W-1:0] memData,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData
);

  import regfile_pkg::state_e;
  import regfile_pkg::S_IDLE;
  import regfile_pkg::S_CLEAR;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_e            state;
  state_e            state_n;
  logic [ADDR_W-1:0] counter;
  logic [ADDR_W-1:0] counter_n;
  logic              reg_write_n;
  logic [ADDR_W-1:0] write_reg_n;
  logic [DATA_W-1:0] write_data_n;
  logic              clear_busy_n;

  logic       arb_en;
  logic [1:0] grant;
  logic       alu_xfer;
  logic       mem_xfer;

  // A clear request pre-empts arbitration in the same cycle.
  assign arb_en   = (state == S_IDLE) && !clearReq;
  assign aluReady = grant[0];
  assign memReady = grant[1];
  assign alu_xfer = aluValid && aluReady;
  assign mem_xfer = memValid && memReady;

  rr_arb2 u_arb (
    .clk     (CLK),
    .rst     (MasterReset),
    .req_alu (aluValid),
    .req_mem (memValid),
    .en      (arb_en),
    .update  (alu_xfer || mem_xfer),
    .grant   (grant)
  );

  always_comb begin
    state_n      = state;
    counter_n    = counter;
    reg_write_n  = 1'b0;
    write_reg_n  = writeReg;
    write_data_n = writeData;
    clear_busy_n = clearBusy;
    case (state)
      S_IDLE: begin
        if (clearReq) begin
          state_n      = S_CLEAR;
          counter_n    = '0;
          reg_write_n  = 1'b1;
          write_reg_n  = '0;
          write_data_n = '0;
          clear_busy_n = 1'b1;
        end else if (alu_xfer) begin
          // Register 0 is hardwired zero: handshake completes, strobe stays low.
          reg_write_n  = (aluReg != '0);
          write_reg_n  = aluReg;
          write_data_n = aluData;
        end else if (mem_xfer) begin
          reg_write_n  = (memReg != '0);
          write_reg_n  = memReg;
          write_data_n = memData;
        end
      end
      S_CLEAR: begin
        // `counter` is the register currently presented on the write port.
        if (counter == LAST_REG) begin
          state_n      = S_IDLE;
          clear_busy_n = 1'b0;
        end else begin
          counter_n    = counter + ADDR_W'(1);
          reg_write_n  = 1'b1;
          write_reg_n  = counter + ADDR_W'(1);
          write_data_n = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge MasterReset) begin
    if (MasterReset) begin
      state     <= S_IDLE;
      counter   <= '0;
      RegWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      clearBusy <= 1'b0;
    end else begin
      state     <= state_n;
      counter   <= counter_n;
      RegWrite  <= reg_write_n;
      writeReg  <= write_reg_n;
      writeData <= write_data_n;
      clearBusy <= clear_busy_n;
    end
  end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched with a scoreboard of expected
// write-port values pushed at each transfer edge and popped half a cycle later.
module tb_regfile_write_sched;

  logic        CLK;
  logic        MasterReset;
  logic        clearReq;
  logic        clearBusy;
  logic        aluValid;
  logic        aluReady;
  logic [4:0]  aluReg;
  logic [31:0] aluData;
  logic        memValid;
  logic        memReady;
  logic [4:0]  memReg;
  logic [31:0] memData;
  logic        RegWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        busy;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];

  regfile_write_sched dut (
    .CLK         (CLK),
    .MasterReset (MasterReset),
    .clearReq    (clearReq),
    .clearBusy   (clearBusy),
    .aluValid    (aluValid),
    .aluReady    (aluReady),
    .aluReg      (aluReg),
    .aluData     (aluData),
    .memValid    (memValid),
    .memReady    (memReady),
    .memReg      (memReg),
    .memData     (memData),
    .RegWrite    (RegWrite),
    .writeReg    (writeReg),
    .writeData   (writeData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(input logic we, input logic [4:0] r,
                              input logic [31:0] d, input logic busy,
                              input logic chk);
    exp_t e;
    e.we = we; e.wreg = r; e.wdata = d; e.busy = busy; e.chk_data = chk;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic cycle(input logic er_alu, input logic er_mem, input exp_t e);
    exp_t got;
    #1;
    check("aluReady", 32'(aluReady), 32'(er_alu));
    check("memReady", 32'(memReady), 32'(er_mem));
    @(posedge CLK);
    sb.push_back(e);
    @(negedge CLK);
    total++;
    assert (sb.size() == 1) passed++;
    else $error("FAIL scoreboard_depth observed=%0d expected=1", sb.size());
    got = sb.pop_front();
    check("RegWrite", 32'(RegWrite), 32'(got.we));
    check("clearBusy", 32'(clearBusy), 32'(got.busy));
    if (got.chk_data) begin
      check("writeReg", 32'(writeReg), 32'(got.wreg));
      check("writeData", writeData, got.wdata);
    end
  endtask

  initial begin
    MasterReset = 1'b1;
    clearReq = 1'b0;
    aluValid = 1'b0; aluReg = '0; aluData = '0;
    memValid = 1'b0; memReg = '0; memData = '0;

    @(negedge CLK);
    check("rst_RegWrite", 32'(RegWrite), 32'd0);
    check("rst_writeReg", 32'(writeReg), 32'd0);
    check("rst_writeData", writeData, 32'd0);
    check("rst_clearBusy", 32'(clearBusy), 32'd0);
    MasterReset = 1'b0;

    // Single ALU write.
    aluValid = 1'b1; aluReg = 5'd5; aluData = 32'h1234;
    cycle(1'b1, 1'b0, mk(1'b1, 5'd5, 32'h1234, 1'b0, 1'b1));
    aluValid = 1'b0;

    // Fresh reset so the first tie goes to the ALU.
    MasterReset = 1'b1; #1; MasterReset = 1'b0;

    // Both held: grants alternate, no bubble.
    aluValid = 1'b1; aluReg = 5'd3; aluData = 32'hA1A1_0001;
    memValid = 1'b1; memReg = 5'd7; memData = 32'hB1B1_0001;
    cycle(1'b1, 1'b0, mk(1'b1, 5'd3, 32'hA1A1_0001, 1'b0, 1'b1));
    aluReg = 5'd4; aluData = 32'hA1A1_0002;
    cycle(1'b0, 1'b1, mk(1'b1, 5'd7, 32'hB1B1_0001, 1'b0, 1'b1));
    memReg = 5'd8; memData = 32'hB1B1_0002;
    cycle(1'b1, 1'b0, mk(1'b1, 5'd4, 32'hA1A1_0002, 1'b0, 1'b1));
    aluReg = 5'd6; aluData = 32'hA1A1_0003;
    cycle(1'b0, 1'b1, mk(1'b1, 5'd8, 32'hB1B1_0002, 1'b0, 1'b1));
    memValid = 1'b0;
    cycle(1'b1, 1'b0, mk(1'b1, 5'd6, 32'hA1A1_0003, 1'b0, 1'b1));
    aluValid = 1'b0;

    // Load to register 0: accepted, no strobe, still counts as MEM grant.
    memValid = 1'b1; memReg = 5'd0; memData = 32'h0000_FFFF;
    cycle(1'b0, 1'b1, mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
    aluValid = 1'b1; aluReg = 5'd9; aluData = 32'h9999_0000;
    memReg = 5'd10; memData = 32'hAAAA_0000;
    cycle(1'b1, 1'b0, mk(1'b1, 5'd9, 32'h9999_0000, 1'b0, 1'b1));
    aluValid = 1'b0;
    cycle(1'b0, 1'b1, mk(1'b1, 5'd10, 32'hAAAA_0000, 1'b0, 1'b1));
    memValid = 1'b0;

    // Clear sweep with an ALU request held throughout.
    aluValid = 1'b1; aluReg = 5'd12; aluData = 32'hC0DE_0012;
    for (int k = 0; k < 32; k++) begin
      clearReq = (k == 0);
      cycle(1'b0, 1'b0, mk(1'b1, 5'(k), 32'h0, 1'b1, 1'b1));
    end
    clearReq = 1'b0;
    cycle(1'b0, 1'b0, mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
    cycle(1'b1, 1'b0, mk(1'b1, 5'd12, 32'hC0DE_0012, 1'b0, 1'b1));
    aluValid = 1'b0;

    // Second clearReq mid-sweep is ignored.
    for (int k = 0; k < 32; k++) begin
      clearReq = (k == 0) || (k == 10);
      cycle(1'b0, 1'b0, mk(1'b1, 5'(k), 32'h0, 1'b1, 1'b1));
    end
    clearReq = 1'b0;
    cycle(1'b0, 1'b0, mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
    cycle(1'b0, 1'b0, mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b0));

    // Reset mid-sweep aborts immediately.
    for (int k = 0; k <= 10; k++) begin
      clearReq = (k == 0);
      cycle(1'b0, 1'b0, mk(1'b1, 5'(k), 32'h0, 1'b1, 1'b1));
    end
    clearReq = 1'b0;
    #2;
    MasterReset = 1'b1;
    #1;
    check("abort_RegWrite", 32'(RegWrite), 32'd0);
    check("abort_clearBusy", 32'(clearBusy), 32'd0);
    check("abort_writeReg", 32'(writeReg), 32'd0);
    @(negedge CLK);
    MasterReset = 1'b0;
    aluValid = 1'b1; aluReg = 5'd20; aluData = 32'h2020_2020;
    cycle(1'b1, 1'b0, mk(1'b1, 5'd20, 32'h2020_2020, 1'b0, 1'b1));
    aluValid = 1'b0;
    cycle(1'b0, 1'b0, mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
